// File: rtl/rf_arbiter_if.sv
// Request/response bundle between two requesters and the register-file arbiter.
// Latency: none (wires only).
// Backpressure: none; each requester holds req until its ack pulse and then drops or re-issues it.
//
// Signals (master = requester side, slave = arbiter side):
//   req0/req1     request from requester 0/1
//   we0/we1       1 = write, 0 = read
//   addr0/addr1   register index 0-7
//   wdata0/wdata1 write data
//   ack0/ack1     one-cycle completion pulse
//   rdata0/rdata1 last read result per requester
//   busy          arbiter is working on an access
interface rf_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [2:0]  addr0;
    logic [2:0]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1, busy
    );
endinterface

// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of an 8 x 32-bit register file with one shared port.
// Latency: req sampled at edge N, ack pulses in the cycle after edge N+1; one access per 3 cycles.
// Backpressure: requests are only sampled in IDLE; a losing or late request stays pending while held.
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      rf_arbiter_if.slave (req/we/addr/wdata in, ack/rdata/busy out)
//
// Build option: define RF_ZERO_REG_EN to hardwire register 0 to zero (writes to it are
// acknowledged but dropped, reads of it return 0). Undefined, register 0 is ordinary.
module rf_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    rf_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Round-robin pointer: which requester wins when both ask at once.
    logic        r_ptr;

    // Command captured from the winner at the IDLE->ACCESS edge.
    logic        r_win;
    logic        r_we;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_rf [8];
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any_req;
    logic        w_win;
    logic        w_sel_we;
    logic [2:0]  w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_start;
    logic        w_commit;
    logic        w_ack0;
    logic        w_ack1;
    logic        w_busy;
    logic        w_wr_ok;
    logic [31:0] w_rd_val;

    assign w_any_req = bus.req0 | bus.req1;

    // Pointer only matters on a true collision; a lone requester always wins.
    always_comb begin
        w_win = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_win = r_ptr;
        end else if (bus.req1) begin
            w_win = 1'b1;
        end
    end

    assign w_sel_we    = w_win ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_win ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_win ? bus.wdata1 : bus.wdata0;

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state and decoded controls
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The register file is touched on the edge leaving ACCESS, so a
                // reset that lands during ACCESS cancels the whole operation.
                w_commit    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_ack0      = ~r_win;
                w_ack1      = r_win;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Command capture; the winner's inputs are ignored after this edge.
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_win   <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Hand priority to the requester that was not just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (w_commit) begin
            r_ptr <= ~r_win;
        end
    end

    //------------------------------------------------------------------
    // Register file and optional zero register
    //------------------------------------------------------------------
`ifdef RF_ZERO_REG_EN
    assign w_wr_ok  = (r_addr != 3'd0);
    assign w_rd_val = (r_addr == 3'd0) ? 32'd0 : r_rf[r_addr];
`else
    assign w_wr_ok  = 1'b1;
    assign w_rd_val = r_rf[r_addr];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_commit && r_we && w_wr_ok) begin
            r_rf[r_addr] <= r_wdata;
        end
    end

    // Each rdata holds until that requester's next read; writes leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_commit && !r_we) begin
            if (r_win) begin
                r_rdata1 <= w_rd_val;
            end else begin
                r_rdata0 <= w_rd_val;
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign bus.ack0   = w_ack0;
    assign bus.ack1   = w_ack1;
    assign bus.busy   = w_busy;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;

endmodule

// File: tb/tb_rf_arbiter.sv
// Testbench for rf_arbiter: directed scenarios plus a transaction-level model
// compared against the DUT outputs on every falling clock edge.
module tb_rf_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rf_arbiter_if bus ();

    rf_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------
    // Model: each accepted request is a transaction occupying three clock
    // edges. Starting at edge s, its effect lands at edge s+1, the ack is
    // visible between edges s+1 and s+2, and the next request can be taken
    // at edge s+3 or later.
    //------------------------------------------------------------------
    logic [31:0] m_rf [8];
    logic [31:0] m_rdata [2];
    logic        m_ptr = 1'b0;
    logic        m_win = 1'b0;
    logic        m_we = 1'b0;
    logic [2:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          k = 0;
    int          m_start = -100;
    int          m_next_free = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_rdata[0]  = '0;
            m_rdata[1]  = '0;
            m_ptr       = 1'b0;
            m_start     = -100;
            m_next_free = 0;
        end else begin
            k++;
            if (k == m_start + 1) begin
                if (m_we) begin
                    if (!(ZERO_REG && m_addr == 3'd0)) m_rf[m_addr] = m_wdata;
                end else begin
                    m_rdata[m_win] = (ZERO_REG && m_addr == 3'd0) ? 32'd0 : m_rf[m_addr];
                end
                m_ptr = !m_win;
            end
            if (k >= m_next_free && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) m_win = m_ptr;
                else                      m_win = bus.req1;
                m_we        = m_win ? bus.we1    : bus.we0;
                m_addr      = m_win ? bus.addr1  : bus.addr0;
                m_wdata     = m_win ? bus.wdata1 : bus.wdata0;
                m_start     = k;
                m_next_free = k + 3;
            end
        end
    end

    logic c_busy, c_ack0, c_ack1;
    always @(negedge clk) begin
        c_busy = (k == m_start) || (k == m_start + 1);
        c_ack0 = (k == m_start + 1) && !m_win;
        c_ack1 = (k == m_start + 1) && m_win;
        chk("mdl_busy",   bus.busy,   c_busy);
        chk("mdl_ack0",   bus.ack0,   c_ack0);
        chk("mdl_ack1",   bus.ack1,   c_ack1);
        chk("mdl_rdata0", bus.rdata0, m_rdata[0]);
        chk("mdl_rdata1", bus.rdata1, m_rdata[1]);
    end

    //------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    //------------------------------------------------------------------
    task automatic drive(input bit id, input bit rq, input bit we,
                         input logic [2:0] addr, input logic [31:0] wd);
        if (id) begin
            bus.req1 = rq; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = rq; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
    endtask

    // One access by a lone requester; lat = falling edges from issue to ack.
    task automatic access(input bit id, input bit we, input logic [2:0] addr,
                          input logic [31:0] wd, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        drive(id, 1'b1, we, addr, wd);
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = id ? bus.ack1 : bus.ack0;
        end
        drive(id, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("ack_seen", got, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first, k0, k1, n0, n1;
        bit done0, done1, seen0;
        int who [$];
        int when [$];
        int exp_who [6] = '{0, 1, 0, 1, 0, 1};

        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_busy",   bus.busy,   1'b0);
        chk("rst_ack0",   bus.ack0,   1'b0);
        chk("rst_ack1",   bus.ack1,   1'b0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        reset_n = 1'b1;

        // Single write then read back
        access(1'b0, 1'b1, 3'd3, 32'haabbccdd, lat);
        chk("wr_latency", lat, 2);
        access(1'b0, 1'b0, 3'd3, 32'd0, lat);
        chk("rd_latency", lat, 2);
        chk("rd3_rdata0", bus.rdata0, 32'haabbccdd);
        chk("rd3_rdata1", bus.rdata1, 32'd0);

        // Collision right after reset: requester 0 first, requester 1 three cycles later
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h11223344);
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'h99887766);
        first = -1; k0 = 0; k1 = 0; done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 20 && !(done0 && done1); i++) begin
            @(negedge clk);
            if (bus.ack0 && !done0) begin
                done0 = 1'b1; k0 = i;
                if (first < 0) first = 0;
                drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
            end
            if (bus.ack1 && !done1) begin
                done1 = 1'b1; k1 = i;
                if (first < 0) first = 1;
                drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
            end
        end
        chk("col_both_acked", {30'd0, done0, done1}, 32'd3);
        chk("col_first",      first, 0);
        chk("col_gap",        k1 - k0, 3);
        chk("col_rdata0_kept", bus.rdata0, 32'd0);
        access(1'b0, 1'b0, 3'd1, 32'd0, lat);
        chk("col_rd1", bus.rdata0, 32'h11223344);
        access(1'b1, 1'b0, 3'd2, 32'd0, lat);
        chk("col_rd2", bus.rdata1, 32'h99887766);
        chk("col_rdata0_hold", bus.rdata0, 32'h11223344);

        // Fairness: both held high for six accesses
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);
        for (int i = 0; i < 40 && who.size() < 6; i++) begin
            @(negedge clk);
            if (bus.ack0) begin who.push_back(0); when.push_back(i); end
            if (bus.ack1) begin who.push_back(1); when.push_back(i); end
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("fair_count", who.size(), 6);
        for (int i = 0; i < 6 && i < who.size(); i++) begin
            chk("fair_order", who[i], exp_who[i]);
            if (i > 0) chk("fair_spacing", when[i] - when[i-1], 3);
        end

        // Reset during ACCESS of a write: no ack, no write
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 32'habcdef12);
        @(posedge clk);
        #2;
        chk("midop_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack0) n0++;
            if (i == 2) reset_n = 1'b1;
        end
        chk("midop_no_ack", n0, 0);
        access(1'b0, 1'b1, 3'd7, 32'h12345678, lat);
        access(1'b0, 1'b0, 3'd7, 32'd0, lat);
        chk("midop_rd7", bus.rdata0, 32'h12345678);
        access(1'b0, 1'b0, 3'd5, 32'd0, lat);
        chk("midop_rd5", bus.rdata0, 32'd0);

        // Zero register
        access(1'b1, 1'b1, 3'd4, 32'h5a5a0004, lat);
        access(1'b1, 1'b0, 3'd4, 32'd0, lat);
        chk("rd4_rdata1", bus.rdata1, 32'h5a5a0004);
        access(1'b0, 1'b1, 3'd0, 32'h11883366, lat);
        access(1'b1, 1'b0, 3'd0, 32'd0, lat);
        chk("zero_reg", bus.rdata1, ZERO_REG ? 32'd0 : 32'h11883366);

        // Request pulsed while busy and gone before IDLE is dropped
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd3, 32'hdeadbeef);
        @(negedge clk);
        chk("drop_busy", bus.busy, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 3'd6, 32'h66666666);
        @(negedge clk);
        seen0 = bus.ack0;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack1) n1++;
        end
        chk("drop_ack0", seen0, 1'b1);
        chk("drop_no_ack1", n1, 0);
        chk("drop_idle", bus.busy, 1'b0);
        access(1'b0, 1'b0, 3'd3, 32'd0, lat);
        chk("drop_rd3", bus.rdata0, 32'hdeadbeef);
        access(1'b0, 1'b0, 3'd6, 32'd0, lat);
        chk("drop_rd6", bus.rdata0, 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
